// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the pipeline SRAM arbiter: FSM states,
// byte-lane decode and the legal range of the strobe-timing parameters.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  localparam int CYCLES_MIN = 1;
  localparam int CYCLES_MAX = 7;

  // Word accesses enable every lane; byte accesses enable only the addressed lane.
  function automatic logic [3:0] lane_be_n(input logic [1:0] lane, input logic isByte);
    logic [3:0] beN;
    beN = 4'b0000;
    if (isByte) begin
      beN = ~(4'b0001 << lane);
    end
    return beN;
  endfunction

  function automatic int clamp_cycles(input int n);
    int r;
    r = n;
    if (r < CYCLES_MIN) r = CYCLES_MIN;
    if (r > CYCLES_MAX) r = CYCLES_MAX;
    return r;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the IF/MEM request ports and the SRAM pad signals; the arbiter
// is the slave, the pipeline plus pad side is the master.
interface sram_arbiter_if #(
  parameter int SRAM_AW = 20
);
  logic               if_req;
  logic [31:0]        if_addr;
  logic               if_ack;
  logic [31:0]        if_rdata;

  logic               mem_req;
  logic               mem_we;
  logic               mem_byte;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic               mem_ack;
  logic [31:0]        mem_rdata;

  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_dout;
  logic [31:0]        sram_din;
  logic               sram_doe;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;
  logic [3:0]         sram_be_n;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, sram_din,
    input  if_ack, if_rdata, mem_ack, mem_rdata,
    input  sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, sram_din,
    output if_ack, if_rdata, mem_ack, mem_rdata,
    output sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: byte-enable decode, store-data replication and
// load-data extraction with sign extension for LB.
module mem_byte_lane
  import sram_arb_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic        byte_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_n_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0] laneByte;

  always_comb begin
    be_n_o  = lane_be_n(lane_i, byte_i);
    wdata_o = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
    case (lane_i)
      2'd0:    laneByte = rdata_i[7:0];
      2'd1:    laneByte = rdata_i[15:8];
      2'd2:    laneByte = rdata_i[23:16];
      default: laneByte = rdata_i[31:24];
    endcase
    rdata_o = byte_i ? {{24{laneByte[7]}}, laneByte} : rdata_i;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM controller shared by instruction fetch and data access:
// grants one requester at a time and sequences the registered pad strobes.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int READ_CYCLES = 2,
  parameter int WRITE_PULSE = 1,
  parameter int SRAM_AW     = 20
) (
  input logic            clk,
  input logic            rst,
  sram_arbiter_if.slave  bus
);

  localparam int          RC_EFF = clamp_cycles(READ_CYCLES);
  localparam int          WP_EFF = clamp_cycles(WRITE_PULSE);
  localparam logic [2:0]  RC3    = RC_EFF[2:0];
  localparam logic [2:0]  WP3    = WP_EFF[2:0];

  state_t             state_q;
  logic [2:0]         cnt_q;
  logic               owner_q;
  logic               byte_q;
  logic [1:0]         lane_q;
  logic               if_ack_q;
  logic               mem_ack_q;
  logic [31:0]        if_rdata_q;
  logic [31:0]        mem_rdata_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [31:0]        sram_dout_q;
  logic               doe_q;
  logic               ce_n_q;
  logic               oe_n_q;
  logic               we_n_q;
  logic [3:0]         be_n_q;

  logic               memElig;
  logic               ifElig;
  logic               grantMem;
  logic               grantAny;
  logic [SRAM_AW-1:0] selWord;
  logic [1:0]         selLane;
  logic [1:0]         laneSel;
  logic               byteSel;
  logic [3:0]         laneBeN;
  logic [31:0]        laneWdata;
  logic [31:0]        laneRdata;

  // A port whose ack is on the bus this cycle sits out this grant decision.
  assign memElig  = bus.mem_req && !mem_ack_q;
  assign ifElig   = bus.if_req && !if_ack_q;
  assign grantMem = memElig;
  assign grantAny = memElig || ifElig;
  assign selWord  = grantMem ? bus.mem_addr[SRAM_AW+1:2] : bus.if_addr[SRAM_AW+1:2];
  assign selLane  = grantMem ? bus.mem_addr[1:0] : bus.if_addr[1:0];
  assign laneSel  = (state_q == IDLE) ? selLane : lane_q;
  assign byteSel  = (state_q == IDLE) ? (grantMem && bus.mem_byte) : byte_q;

  mem_byte_lane u_lane (
    .lane_i  (laneSel),
    .byte_i  (byteSel),
    .wdata_i (bus.mem_wdata),
    .rdata_i (bus.sram_din),
    .be_n_o  (laneBeN),
    .wdata_o (laneWdata),
    .rdata_o (laneRdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      owner_q     <= 1'b0;
      byte_q      <= 1'b0;
      lane_q      <= 2'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      sram_addr_q <= '0;
      sram_dout_q <= 32'd0;
      doe_q       <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantAny) begin
            owner_q     <= grantMem;
            byte_q      <= byteSel;
            lane_q      <= selLane;
            sram_addr_q <= selWord;
            be_n_q      <= laneBeN;
            ce_n_q      <= 1'b0;
            if (grantMem && bus.mem_we) begin
              sram_dout_q <= laneWdata;
              doe_q       <= 1'b1;
              state_q     <= WR_SETUP;
            end else begin
              oe_n_q  <= 1'b0;
              cnt_q   <= RC3;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (cnt_q == 3'd1) begin
            if (owner_q) begin
              mem_rdata_q <= laneRdata;
              mem_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= laneRdata;
              if_ack_q   <= 1'b1;
            end
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        WR_SETUP: begin
          we_n_q  <= 1'b0;
          cnt_q   <= WP3;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt_q == 3'd1) begin
            we_n_q  <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        WR_HOLD: begin
          ce_n_q    <= 1'b1;
          doe_q     <= 1'b0;
          be_n_q    <= 4'hF;
          mem_ack_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_dout = sram_dout_q;
  assign bus.sram_doe  = doe_q;
  assign bus.sram_ce_n = ce_n_q;
  assign bus.sram_oe_n = oe_n_q;
  assign bus.sram_we_n = we_n_q;
  assign bus.sram_be_n = be_n_q;

endmodule
